// File: rtl/ppu_pkg.sv
// Shared PPU definitions: scanline geometry, palette/RGB widths, layer codes, mixer states.
package ppu_pkg;

    localparam int unsigned NUM_PIXELS_DEF = 320;
    localparam int unsigned PIX_W          = 9;
    localparam int unsigned PIXD_W         = 8;
    localparam int unsigned PAL_AW         = 10;
    localparam int unsigned RGB_W          = 24;

    typedef enum logic [1:0] {
        LAYER_BG  = 2'b00,
        LAYER_FG  = 2'b01,
        LAYER_SPR = 2'b10
    } layer_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        MIX  = 2'd2,
        FIN  = 2'd3
    } mixer_state_t;

    // Palette RAM address payload: {layer, palette, colour}
    typedef struct packed {
        layer_e     layer;
        logic [3:0] palette;
        logic [3:0] colour;
    } pal_addr_t;

    // Colour index 0 marks a transparent pixel
    function automatic logic is_opaque(input logic [PIXD_W-1:0] pix);
        return pix[3:0] != 4'd0;
    endfunction

endpackage

// File: rtl/pixmix_layer_select.sv
// Combinational front-most-layer resolver producing the palette RAM address.
// Sprite layer participates only when PIXEL_MIXER_SPRITE_EN is defined.
module pixmix_layer_select
    import ppu_pkg::*;
(
    input  logic [PIXD_W-1:0] bg_pix_i,
    input  logic [PIXD_W-1:0] fg_pix_i,
`ifdef PIXEL_MIXER_SPRITE_EN
    input  logic [PIXD_W:0]   spr_pix_i,
`endif
    output pal_addr_t         sel_o
);

    // Priority pick; all-transparent falls through to the backdrop entry (address 0)
    always_comb begin
        sel_o = '0;
`ifdef PIXEL_MIXER_SPRITE_EN
        if (is_opaque(spr_pix_i[PIXD_W-1:0]) && !spr_pix_i[PIXD_W]) begin
            sel_o = '{layer: LAYER_SPR, palette: spr_pix_i[7:4], colour: spr_pix_i[3:0]};
        end else if (is_opaque(fg_pix_i)) begin
            sel_o = '{layer: LAYER_FG, palette: fg_pix_i[7:4], colour: fg_pix_i[3:0]};
        end else if (is_opaque(spr_pix_i[PIXD_W-1:0])) begin
            sel_o = '{layer: LAYER_SPR, palette: spr_pix_i[7:4], colour: spr_pix_i[3:0]};
        end else if (is_opaque(bg_pix_i)) begin
            sel_o = '{layer: LAYER_BG, palette: bg_pix_i[7:4], colour: bg_pix_i[3:0]};
        end
`else
        if (is_opaque(fg_pix_i)) begin
            sel_o = '{layer: LAYER_FG, palette: fg_pix_i[7:4], colour: fg_pix_i[3:0]};
        end else if (is_opaque(bg_pix_i)) begin
            sel_o = '{layer: LAYER_BG, palette: bg_pix_i[7:4], colour: bg_pix_i[3:0]};
        end
`endif
    end

endmodule

// File: rtl/pixel_mixer.sv
// Scanline pixel mixer: waits for the layer engines, then streams NUM_PIXELS pixels
// through layer select and palette lookup into the row buffer at 1 pixel/cycle.
// Optional sprite layer: define PIXEL_MIXER_SPRITE_EN.
// palram_addr and rowbuf_wrdata are combinational so the palette read fits the
// 2-stage pipeline; both are forced to 0 outside valid pipeline slots.
module pixel_mixer
    import ppu_pkg::*;
#(
    parameter int unsigned NUM_PIXELS = NUM_PIXELS_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic                tile_prep,
    input  logic                bg_done,
    input  logic                fg_done,
`ifdef PIXEL_MIXER_SPRITE_EN
    output logic                spr_prep,
    input  logic                spr_done,
    input  logic [PIXD_W:0]     spr_pixel_data,
`endif
    output logic [PIX_W-1:0]    pixel_addr,
    input  logic [PIXD_W-1:0]   bg_pixel_data,
    input  logic [PIXD_W-1:0]   fg_pixel_data,
    output logic [PAL_AW-1:0]   palram_addr,
    input  logic [RGB_W-1:0]    palram_rddata,
    output logic [PIX_W-1:0]    rowbuf_addr,
    output logic [RGB_W-1:0]    rowbuf_wrdata,
    output logic                rowbuf_wren
);

    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(NUM_PIXELS - 1);

    mixer_state_t      state_q;
    logic              busy_q;
    logic              done_q;
    logic              tile_prep_q;
    logic              bg_lat_q;
    logic              fg_lat_q;
    logic [PIX_W-1:0]  pixel_addr_q;
    logic              addr_valid_q;
    logic              drain_q;
    logic              s1_valid_q;
    logic [PIX_W-1:0]  s1_idx_q;
    logic              wren_q;
    logic [PIX_W-1:0]  wr_addr_q;

    logic              bg_lat_d;
    logic              fg_lat_d;
    logic              all_done_c;
    pal_addr_t         sel_c;
    logic [PAL_AW-1:0] sel_bits_c;

    assign bg_lat_d = bg_lat_q | bg_done;
    assign fg_lat_d = fg_lat_q | fg_done;

`ifdef PIXEL_MIXER_SPRITE_EN
    logic spr_prep_q;
    logic spr_lat_q;
    logic spr_lat_d;
    assign spr_lat_d  = spr_lat_q | spr_done;
    assign all_done_c = bg_lat_d & fg_lat_d & spr_lat_d;
    assign spr_prep   = spr_prep_q;
`else
    assign all_done_c = bg_lat_d & fg_lat_d;
`endif

    // Scanline control FSM: prep handshake, pixel address generation, pipeline drain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            tile_prep_q  <= 1'b0;
            bg_lat_q     <= 1'b0;
            fg_lat_q     <= 1'b0;
            pixel_addr_q <= '0;
            addr_valid_q <= 1'b0;
            drain_q      <= 1'b0;
`ifdef PIXEL_MIXER_SPRITE_EN
            spr_prep_q   <= 1'b0;
            spr_lat_q    <= 1'b0;
`endif
        end else begin
            tile_prep_q <= 1'b0;
            done_q      <= 1'b0;
`ifdef PIXEL_MIXER_SPRITE_EN
            spr_prep_q  <= 1'b0;
`endif
            unique case (state_q)
                IDLE: begin
                    bg_lat_q <= 1'b0;
                    fg_lat_q <= 1'b0;
`ifdef PIXEL_MIXER_SPRITE_EN
                    spr_lat_q <= 1'b0;
`endif
                    if (start) begin
                        state_q     <= PREP;
                        busy_q      <= 1'b1;
                        tile_prep_q <= 1'b1;
`ifdef PIXEL_MIXER_SPRITE_EN
                        spr_prep_q  <= 1'b1;
`endif
                    end
                end
                PREP: begin
                    bg_lat_q <= bg_lat_d;
                    fg_lat_q <= fg_lat_d;
`ifdef PIXEL_MIXER_SPRITE_EN
                    spr_lat_q <= spr_lat_d;
`endif
                    if (all_done_c) begin
                        state_q      <= MIX;
                        pixel_addr_q <= '0;
                        addr_valid_q <= 1'b1;
                        drain_q      <= 1'b0;
                    end
                end
                MIX: begin
                    if (addr_valid_q) begin
                        if (pixel_addr_q == LAST_PIX) begin
                            addr_valid_q <= 1'b0;
                        end else begin
                            pixel_addr_q <= pixel_addr_q + PIX_W'(1);
                        end
                    end else if (drain_q) begin
                        state_q <= FIN;
                        done_q  <= 1'b1;
                    end else begin
                        drain_q <= 1'b1;
                    end
                end
                FIN: begin
                    state_q      <= IDLE;
                    busy_q       <= 1'b0;
                    pixel_addr_q <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Pixel pipeline: stage 1 resolves the layer, stage 2 writes the palette colour
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_idx_q   <= '0;
            wren_q     <= 1'b0;
            wr_addr_q  <= '0;
        end else begin
            s1_valid_q <= addr_valid_q;
            s1_idx_q   <= pixel_addr_q;
            wren_q     <= s1_valid_q;
            wr_addr_q  <= s1_idx_q;
        end
    end

    pixmix_layer_select u_layer_select (
        .bg_pix_i  (bg_pixel_data),
        .fg_pix_i  (fg_pixel_data),
`ifdef PIXEL_MIXER_SPRITE_EN
        .spr_pix_i (spr_pixel_data),
`endif
        .sel_o     (sel_c)
    );

    assign sel_bits_c    = sel_c;
    assign busy          = busy_q;
    assign done          = done_q;
    assign tile_prep     = tile_prep_q;
    assign pixel_addr    = pixel_addr_q;
    assign palram_addr   = s1_valid_q ? sel_bits_c : '0;
    assign rowbuf_addr   = wr_addr_q;
    assign rowbuf_wren   = wren_q;
    assign rowbuf_wrdata = wren_q ? palram_rddata : '0;

endmodule

// File: tb/tb_pixel_mixer.sv
// Directed bench for pixel_mixer with behavioural layer engines, palette RAM and a
// row-buffer scoreboard. Sprite lines are exercised when PIXEL_MIXER_SPRITE_EN is defined.
module tb_pixel_mixer;
    import ppu_pkg::*;

    localparam int NP = 320;

    logic        clk = 1'b0;
    logic        rst_n, start, bg_done, fg_done;
    logic        busy, done, tile_prep, rowbuf_wren;
    logic [8:0]  pixel_addr, rowbuf_addr;
    logic [7:0]  bg_pixel_data = 8'h00;
    logic [7:0]  fg_pixel_data = 8'h00;
    logic [9:0]  palram_addr;
    logic [23:0] palram_rddata = 24'h0;
    logic [23:0] rowbuf_wrdata;
`ifdef PIXEL_MIXER_SPRITE_EN
    logic        spr_prep, spr_done;
    logic [8:0]  spr_pixel_data = 9'h000;
    logic [8:0]  spr_mem [NP];
`endif

    logic [7:0]  bg_mem [NP];
    logic [7:0]  fg_mem [NP];

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          n_wr = 0, n_done = 0, n_prep = 0, first_wr_cyc = -1;
    int          q_idx [$];
    logic [9:0]  q_pa [$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    pixel_mixer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .busy           (busy),
        .done           (done),
        .tile_prep      (tile_prep),
        .bg_done        (bg_done),
        .fg_done        (fg_done),
`ifdef PIXEL_MIXER_SPRITE_EN
        .spr_prep       (spr_prep),
        .spr_done       (spr_done),
        .spr_pixel_data (spr_pixel_data),
`endif
        .pixel_addr     (pixel_addr),
        .bg_pixel_data  (bg_pixel_data),
        .fg_pixel_data  (fg_pixel_data),
        .palram_addr    (palram_addr),
        .palram_rddata  (palram_rddata),
        .rowbuf_addr    (rowbuf_addr),
        .rowbuf_wrdata  (rowbuf_wrdata),
        .rowbuf_wren    (rowbuf_wren)
    );

    // Address-derived RGB, distinct for every palette address
    function automatic logic [23:0] rgb_of(input logic [9:0] a);
        return {6'h2A, a, ~a[7:0]};
    endfunction

    // Reference layer priority: sprite (unless behind-FG), FG, sprite, BG, backdrop
    function automatic logic [9:0] exp_pa(input logic [7:0] bg, input logic [7:0] fg, input logic [8:0] spr);
        if (spr[3:0] != 4'h0 && !spr[8]) return {2'b10, spr[7:0]};
        if (fg[3:0] != 4'h0)             return {2'b01, fg};
        if (spr[3:0] != 4'h0)            return {2'b10, spr[7:0]};
        if (bg[3:0] != 4'h0)             return {2'b00, bg};
        return 10'h000;
    endfunction

    function automatic logic [8:0] spr_at(input int i);
`ifdef PIXEL_MIXER_SPRITE_EN
        return spr_mem[i];
`else
        return (i < 0) ? 9'h1FF : 9'h000;
`endif
    endfunction

    // Behavioural layer engines and palette RAM: one-cycle read latency
    always @(posedge clk) begin
        bg_pixel_data <= (int'(pixel_addr) < NP) ? bg_mem[int'(pixel_addr)] : 8'h00;
        fg_pixel_data <= (int'(pixel_addr) < NP) ? fg_mem[int'(pixel_addr)] : 8'h00;
`ifdef PIXEL_MIXER_SPRITE_EN
        spr_pixel_data <= (int'(pixel_addr) < NP) ? spr_mem[int'(pixel_addr)] : 9'h000;
`endif
        palram_rddata <= rgb_of(palram_addr);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Row-buffer monitor and event counters
    always @(negedge clk) begin
        int         idx;
        logic [9:0] pa;
        if (tile_prep) n_prep++;
        if (done) n_done++;
        if (rowbuf_wren) begin
            if (n_wr == 0) first_wr_cyc = cyc;
            n_wr++;
            chk("sb_pending", 32'(q_idx.size() > 0), 32'd1);
            if (q_idx.size() > 0) begin
                idx = q_idx.pop_front();
                pa  = q_pa.pop_front();
                chk("rowbuf_addr", 32'(rowbuf_addr), 32'(idx));
                chk("rowbuf_wrdata", 32'(rowbuf_wrdata), 32'(rgb_of(pa)));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_line(input logic [7:0] bgv, input logic [7:0] fgv);
        for (int i = 0; i < NP; i++) begin
            bg_mem[i] = bgv;
            fg_mem[i] = fgv;
`ifdef PIXEL_MIXER_SPRITE_EN
            spr_mem[i] = 9'h000;
`endif
        end
    endtask

    task automatic push_expect();
        q_idx.delete();
        q_pa.delete();
        for (int i = 0; i < NP; i++) begin
            q_idx.push_back(i);
            q_pa.push_back(exp_pa(bg_mem[i], fg_mem[i], spr_at(i)));
        end
        n_wr = 0; n_done = 0; n_prep = 0; first_wr_cyc = -1;
    endtask

    task automatic issue_start();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic engines_done(output int e);
        bg_done = 1'b1;
        fg_done = 1'b1;
`ifdef PIXEL_MIXER_SPRITE_EN
        spr_done = 1'b1;
`endif
        e = cyc;
        tick();
        bg_done = 1'b0;
        fg_done = 1'b0;
`ifdef PIXEL_MIXER_SPRITE_EN
        spr_done = 1'b0;
`endif
    endtask

    task automatic wait_done(input string tag, output int at);
        bit found = 0;
        at = -1;
        for (int k = 0; k < 1000 && !found; k++) begin
            @(negedge clk);
            if (done) begin
                found = 1;
                at = cyc;
            end
        end
        chk({tag, "_done_seen"}, 32'(found), 32'd1);
    endtask

    task automatic line_end(input string tag);
        tick();
        chk({tag, "_done_pulse_low"}, 32'(done), 32'd0);
        chk({tag, "_busy_idle"}, 32'(busy), 32'd0);
        chk({tag, "_writes"}, 32'(n_wr), 32'd320);
        chk({tag, "_sb_empty"}, 32'(q_idx.size()), 32'd0);
        chk({tag, "_done_count"}, 32'(n_done), 32'd1);
    endtask

    // Full scanline with start/prep/MIX timing checks
    task automatic run_line(input string tag);
        int e, at;
        push_expect();
        issue_start();
        chk({tag, "_tile_prep"}, 32'(tile_prep), 32'd1);
`ifdef PIXEL_MIXER_SPRITE_EN
        chk({tag, "_spr_prep"}, 32'(spr_prep), 32'd1);
`endif
        chk({tag, "_busy"}, 32'(busy), 32'd1);
        tick();
        chk({tag, "_tile_prep_1cyc"}, 32'(tile_prep), 32'd0);
        tick();
        chk({tag, "_no_write_in_prep"}, 32'(rowbuf_wren), 32'd0);
        engines_done(e);
        chk({tag, "_pix0"}, 32'(pixel_addr), 32'd0);
        tick();
        chk({tag, "_pix1"}, 32'(pixel_addr), 32'd1);
        wait_done(tag, at);
        chk({tag, "_done_cycle"}, 32'(at), 32'(e + 323));
        chk({tag, "_first_write_cycle"}, 32'(first_wr_cyc), 32'(e + 3));
        line_end(tag);
    endtask

    initial begin
        int e, at;
        bit hit;
        rst_n = 1'b0; start = 1'b0; bg_done = 1'b0; fg_done = 1'b0;
`ifdef PIXEL_MIXER_SPRITE_EN
        spr_done = 1'b0;
`endif
        load_line(8'h00, 8'h00);
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_tile_prep", 32'(tile_prep), 32'd0);
        chk("rst_pixel_addr", 32'(pixel_addr), 32'd0);
        chk("rst_palram_addr", 32'(palram_addr), 32'd0);
        chk("rst_rowbuf_wren", 32'(rowbuf_wren), 32'd0);
        chk("rst_rowbuf_addr", 32'(rowbuf_addr), 32'd0);
        chk("rst_rowbuf_wrdata", 32'(rowbuf_wrdata), 32'd0);
        tick();
        rst_n = 1'b1;

        // BG only, FG transparent everywhere
        load_line(8'h35, 8'h00);
        run_line("bg_only");

        // FG window over BG
        load_line(8'h35, 8'h00);
        for (int i = 100; i <= 107; i++) fg_mem[i] = 8'h12;
        run_line("fg_window");

        // Both layers transparent with nonzero palettes: backdrop
        load_line(8'h30, 8'h50);
        run_line("backdrop");

        // Staggered engine dones, stray done in IDLE, ignored mid-MIX start
        load_line(8'h47, 8'h00);
        for (int i = 0; i < NP; i += 7) fg_mem[i] = 8'h9C;
        tick();
        bg_done = 1'b1;
        tick();
        bg_done = 1'b0;
        push_expect();
        issue_start();
        tick();
        fg_done = 1'b1;
        tick();
        fg_done = 1'b0;
        repeat (3) tick();
        chk("stagger_still_prep_addr", 32'(pixel_addr), 32'd0);
        chk("stagger_still_prep_busy", 32'(busy), 32'd1);
        chk("stagger_no_write", 32'(n_wr), 32'd0);
        tick();
        bg_done = 1'b1;
        e = cyc;
        tick();
        bg_done = 1'b0;
        tick();
        chk("stagger_pix1", 32'(pixel_addr), 32'd1);
        repeat (150) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("stagger", at);
        chk("stagger_done_cycle", 32'(at), 32'(e + 323));
        repeat (20) tick();
        chk("stagger_prep_count", 32'(n_prep), 32'd1);
        line_end("stagger");

        // Reset mid-line at pixel 150
        load_line(8'h35, 8'h00);
        push_expect();
        issue_start();
        tick();
        engines_done(e);
        hit = 0;
        for (int k = 0; k < 400 && !hit; k++) begin
            @(negedge clk);
            if (pixel_addr == 9'd150) hit = 1;
        end
        chk("abort_reached_150", 32'(hit), 32'd1);
        #2 rst_n = 1'b0;
        @(negedge clk);
        chk("abort_wren", 32'(rowbuf_wren), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_pixel_addr", 32'(pixel_addr), 32'd0);
        chk("abort_palram_addr", 32'(palram_addr), 32'd0);
        chk("abort_rowbuf_wrdata", 32'(rowbuf_wrdata), 32'd0);
        chk("abort_writes_before", 32'(n_wr), 32'd149);
        repeat (3) tick();
        rst_n = 1'b1;
        repeat (200) tick();
        chk("abort_no_done", 32'(n_done), 32'd0);
        chk("abort_no_late_writes", 32'(n_wr), 32'd149);
        load_line(8'h6B, 8'h00);
        for (int i = 300; i < NP; i++) fg_mem[i] = 8'hE1;
        run_line("after_abort");

`ifdef PIXEL_MIXER_SPRITE_EN
        // Sprite priority: in front, behind FG, behind FG with FG transparent
        load_line(8'h35, 8'h00);
        for (int i = 10; i <= 29; i++) fg_mem[i] = 8'h12;
        for (int i = 10; i <= 19; i++) spr_mem[i] = 9'h0A7;
        for (int i = 20; i <= 39; i++) spr_mem[i] = 9'h1A7;
        chk("spr_front_model", 32'(exp_pa(8'h35, 8'h12, 9'h0A7)), 32'h2A7);
        run_line("sprite");
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
